// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM state enum and its width.
package mem_port_arbiter_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT,
    RELAY
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational round-robin picker: first requesting port at or after rr_ptr.
module rr_picker #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned PTR_W     = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_W-1:0]     rr_ptr,
  output logic [PTR_W-1:0]     grant_idx,
  output logic                 any_valid
);

  localparam int unsigned CW = PTR_W + 1;

  // one spare bit so rr_ptr + offset can exceed NUM_PORTS before wrapping
  logic [CW-1:0] cand;

  always_comb begin
    grant_idx = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = {1'b0, rr_ptr} + CW'(i);
      if (cand >= CW'(NUM_PORTS)) begin
        cand = cand - CW'(NUM_PORTS);
      end
      if (!any_valid && req[cand[PTR_W-1:0]]) begin
        any_valid = 1'b1;
        grant_idx = cand[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port among NUM_PORTS requesters.
// Define MEM_PORT_ARBITER_PERF_EN to add grant_count / stall_cycles outputs.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_PORTS-1:0]                 consumer_read_valid,
  input  logic [NUM_PORTS-1:0][ADDR_BITS-1:0]  consumer_read_address,
  output logic [NUM_PORTS-1:0]                 consumer_read_ready,
  output logic [NUM_PORTS-1:0][DATA_BITS-1:0]  consumer_read_data,
  input  logic [NUM_PORTS-1:0]                 consumer_write_valid,
  input  logic [NUM_PORTS-1:0][ADDR_BITS-1:0]  consumer_write_address,
  input  logic [NUM_PORTS-1:0][DATA_BITS-1:0]  consumer_write_data,
  output logic [NUM_PORTS-1:0]                 consumer_write_ready,
  output logic                                 mem_read_valid,
  output logic [ADDR_BITS-1:0]                 mem_read_address,
  input  logic                                 mem_read_ready,
  input  logic [DATA_BITS-1:0]                 mem_read_data,
  output logic                                 mem_write_valid,
  output logic [ADDR_BITS-1:0]                 mem_write_address,
  output logic [DATA_BITS-1:0]                 mem_write_data,
  input  logic                                 mem_write_ready
`ifdef MEM_PORT_ARBITER_PERF_EN
  ,
  output logic [15:0]                          grant_count,
  output logic [15:0]                          stall_cycles
`endif
);

  localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  arb_state_e                          state_q, state_d;
  logic [PTR_W-1:0]                    port_q, port_d;
  logic [PTR_W-1:0]                    rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0]                rd_ready_q, rd_ready_d;
  logic [NUM_PORTS-1:0]                wr_ready_q, wr_ready_d;
  logic [NUM_PORTS-1:0][DATA_BITS-1:0] rd_data_q, rd_data_d;
  logic                                mrv_q, mrv_d;
  logic                                mwv_q, mwv_d;
  logic [ADDR_BITS-1:0]                mra_q, mra_d;
  logic [ADDR_BITS-1:0]                mwa_q, mwa_d;
  logic [DATA_BITS-1:0]                mwd_q, mwd_d;

  logic [NUM_PORTS-1:0] req_any;
  logic [PTR_W-1:0]     grant_idx;
  logic                 any_valid;
  logic                 relay_done;

  assign req_any = consumer_read_valid | consumer_write_valid;

  rr_picker #(
    .NUM_PORTS(NUM_PORTS),
    .PTR_W    (PTR_W)
  ) u_picker (
    .req      (req_any),
    .rr_ptr   (rr_ptr_q),
    .grant_idx(grant_idx),
    .any_valid(any_valid)
  );

  // the ready that is currently high tells which valid ends the relay
  assign relay_done = rd_ready_q[port_q] ? !consumer_read_valid[port_q]
                                         : !consumer_write_valid[port_q];

  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    rr_ptr_d   = rr_ptr_q;
    rd_ready_d = rd_ready_q;
    wr_ready_d = wr_ready_q;
    rd_data_d  = rd_data_q;
    mrv_d      = mrv_q;
    mwv_d      = mwv_q;
    mra_d      = mra_q;
    mwa_d      = mwa_q;
    mwd_d      = mwd_q;
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          port_d = grant_idx;
          if (consumer_read_valid[grant_idx]) begin
            mrv_d   = 1'b1;
            mra_d   = consumer_read_address[grant_idx];
            state_d = READ_WAIT;
          end else begin
            mwv_d   = 1'b1;
            mwa_d   = consumer_write_address[grant_idx];
            mwd_d   = consumer_write_data[grant_idx];
            state_d = WRITE_WAIT;
          end
        end
      end
      READ_WAIT: begin
        if (mem_read_ready) begin
          mrv_d              = 1'b0;
          rd_data_d[port_q]  = mem_read_data;
          rd_ready_d[port_q] = 1'b1;
          state_d            = RELAY;
        end
      end
      WRITE_WAIT: begin
        if (mem_write_ready) begin
          mwv_d              = 1'b0;
          wr_ready_d[port_q] = 1'b1;
          state_d            = RELAY;
        end
      end
      RELAY: begin
        if (relay_done) begin
          rd_ready_d = '0;
          wr_ready_d = '0;
          rr_ptr_d   = (port_q == PTR_W'(NUM_PORTS - 1)) ? '0 : port_q + PTR_W'(1);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      port_q     <= '0;
      rr_ptr_q   <= '0;
      rd_ready_q <= '0;
      wr_ready_q <= '0;
      rd_data_q  <= '0;
      mrv_q      <= 1'b0;
      mwv_q      <= 1'b0;
      mra_q      <= '0;
      mwa_q      <= '0;
      mwd_q      <= '0;
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      rr_ptr_q   <= rr_ptr_d;
      rd_ready_q <= rd_ready_d;
      wr_ready_q <= wr_ready_d;
      rd_data_q  <= rd_data_d;
      mrv_q      <= mrv_d;
      mwv_q      <= mwv_d;
      mra_q      <= mra_d;
      mwa_q      <= mwa_d;
      mwd_q      <= mwd_d;
    end
  end

  assign consumer_read_ready  = rd_ready_q;
  assign consumer_write_ready = wr_ready_q;
  assign consumer_read_data   = rd_data_q;
  assign mem_read_valid       = mrv_q;
  assign mem_read_address     = mra_q;
  assign mem_write_valid      = mwv_q;
  assign mem_write_address    = mwa_q;
  assign mem_write_data       = mwd_q;

`ifdef MEM_PORT_ARBITER_PERF_EN
  logic [15:0] grant_count_q, grant_count_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    grant_count_d  = grant_count_q;
    stall_cycles_d = stall_cycles_q;
    if (state_q == IDLE && any_valid) begin
      grant_count_d = grant_count_q + 16'd1;
    end
    if ((state_q == READ_WAIT || state_q == WRITE_WAIT) && stall_cycles_q != 16'hFFFF) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      grant_count_q  <= '0;
      stall_cycles_q <= '0;
    end else begin
      grant_count_q  <= grant_count_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign grant_count  = grant_count_q;
  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-ownership model plus directed scenarios.
module tb_mem_port_arbiter;

  localparam int NP = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      rv, wv;
  logic [3:0][7:0] ra, wa, wd;
  logic [3:0]      crr, cwr;
  logic [3:0][7:0] crd;
  logic            mrv, mwv, mrr, mwr;
  logic [7:0]      mra, mwa, mwd, mrd;
`ifdef MEM_PORT_ARBITER_PERF_EN
  logic [15:0]     gcnt, scnt;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .NUM_PORTS(4),
    .ADDR_BITS(8),
    .DATA_BITS(8)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .consumer_read_valid   (rv),
    .consumer_read_address (ra),
    .consumer_read_ready   (crr),
    .consumer_read_data    (crd),
    .consumer_write_valid  (wv),
    .consumer_write_address(wa),
    .consumer_write_data   (wd),
    .consumer_write_ready  (cwr),
    .mem_read_valid        (mrv),
    .mem_read_address      (mra),
    .mem_read_ready        (mrr),
    .mem_read_data         (mrd),
    .mem_write_valid       (mwv),
    .mem_write_address     (mwa),
    .mem_write_data        (mwd),
    .mem_write_ready       (mwr)
`ifdef MEM_PORT_ARBITER_PERF_EN
    ,
    .grant_count           (gcnt),
    .stall_cycles          (scnt)
`endif
  );

  int tests = 0;
  int fails = 0;

  // reference model: who owns the memory, and whether it is waiting on memory
  int              owner;
  bit              own_rd;
  bit              pend;
  int              ptr;
  bit              mvalid = 1'b0;
  logic [3:0]      e_crr, e_cwr;
  logic [3:0][7:0] e_crd;
  logic            e_mrv, e_mwv;
  logic [7:0]      e_mra, e_mwa, e_mwd;
  int              e_gcnt, e_scnt;
  int              grants[$];

  // bench-side memory and consumer behaviour
  int mem_lat = 0;
  bit spur = 1'b0;
  int rcnt = 0, wcnt = 0;
  int hold[4];
  int hcnt[4];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_step();
    bit found;
    int p;
    if (!reset) begin
      owner = -1; pend = 1'b0; ptr = 0;
      e_crr = '0; e_cwr = '0; e_crd = '0;
      e_mrv = 1'b0; e_mwv = 1'b0; e_mra = '0; e_mwa = '0; e_mwd = '0;
      e_gcnt = 0; e_scnt = 0;
    end else if (owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < NP; k++) begin
        p = (ptr + k) % NP;
        if (!found && (rv[p] || wv[p])) begin
          found  = 1'b1;
          owner  = p;
          own_rd = rv[p];
          pend   = 1'b1;
          grants.push_back(p);
          e_gcnt = (e_gcnt + 1) % 65536;
          if (own_rd) begin
            e_mrv = 1'b1; e_mra = ra[p];
          end else begin
            e_mwv = 1'b1; e_mwa = wa[p]; e_mwd = wd[p];
          end
        end
      end
    end else if (pend) begin
      if (e_scnt < 65535) e_scnt++;
      if (own_rd && mrr) begin
        pend = 1'b0; e_mrv = 1'b0; e_crd[owner] = mrd; e_crr[owner] = 1'b1;
      end else if (!own_rd && mwr) begin
        pend = 1'b0; e_mwv = 1'b0; e_cwr[owner] = 1'b1;
      end
    end else begin
      if (own_rd ? !rv[owner] : !wv[owner]) begin
        e_crr = '0; e_cwr = '0;
        ptr   = (owner + 1) % NP;
        owner = -1;
      end
    end
    mvalid = 1'b1;
  endfunction

  function automatic void compare_all();
    if (mvalid) begin
      chk("crr", 32'(crr), 32'(e_crr));
      chk("cwr", 32'(cwr), 32'(e_cwr));
      chk("crd", 32'(crd), 32'(e_crd));
      chk("mrv", 32'(mrv), 32'(e_mrv));
      chk("mwv", 32'(mwv), 32'(e_mwv));
      chk("mra", 32'(mra), 32'(e_mra));
      chk("mwa", 32'(mwa), 32'(e_mwa));
      chk("mwd", 32'(mwd), 32'(e_mwd));
`ifdef MEM_PORT_ARBITER_PERF_EN
      chk("gcnt", 32'(gcnt), 32'(e_gcnt));
      chk("scnt", 32'(scnt), 32'(e_scnt));
`endif
    end
  endfunction

  function automatic void drive_step();
    if (mrv) begin
      rcnt++;
      mrr = (rcnt > mem_lat);
      mrd = mra ^ 8'h4A;
    end else begin
      rcnt = 0;
      mrr  = spur;
      if (spur) mrd = 8'hEE;
    end
    if (mwv) begin
      wcnt++;
      mwr = (wcnt > mem_lat);
    end else begin
      wcnt = 0;
      mwr  = spur;
    end
    for (int p = 0; p < NP; p++) begin
      if ((crr[p] && rv[p]) || (cwr[p] && wv[p])) begin
        if (hcnt[p] >= hold[p]) begin
          if (crr[p]) rv[p] = 1'b0;
          else        wv[p] = 1'b0;
          hcnt[p] = 0;
        end else begin
          hcnt[p]++;
        end
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    drive_step();
  endtask

  task automatic wait_ready(input int p, input bit rd, input int max, output int n);
    n = 0;
    while (n < max && !(rd ? crr[p] : cwr[p])) begin
      tick();
      n++;
    end
    tests++;
    if (!(rd ? crr[p] : cwr[p])) begin
      fails++;
      $display("FAIL wait_ready port %0d: got no ready expected ready within %0d cycles", p, max);
    end
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while (n < max && !(rv == 4'h0 && wv == 4'h0 && owner < 0)) begin
      tick();
      n++;
    end
    tests++;
    if (!(rv == 4'h0 && wv == 4'h0 && owner < 0)) begin
      fails++;
      $display("FAIL wait_idle: got busy expected idle within %0d cycles", max);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    rv = '0; wv = '0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    int n, hc;
    logic [7:0] cap_wa, cap_wd;
    reset = 1'b0;
    rv = '0; wv = '0; ra = '0; wa = '0; wd = '0;
    mrr = 1'b0; mwr = 1'b0; mrd = '0;
    for (int p = 0; p < NP; p++) begin hold[p] = 0; hcnt[p] = 0; end
    repeat (3) tick();
    chk("rst_crr", 32'(crr), 32'h0);
    chk("rst_crd", 32'(crd), 32'h0);
    chk("rst_mrv", 32'(mrv), 32'h0);
    reset = 1'b1;
    tick();

    // port 2 read of 0x10 with three-cycle memory
    mem_lat = 2;
    ra[2] = 8'h10; rv[2] = 1'b1;
    wait_ready(2, 1'b1, 20, n);
    chk("lat032", 32'(n), 32'd4);
    chk("rd032", 32'(crd[2]), 32'h5A);
    chk("mrv032", 32'(mrv), 32'h0);
    wait_idle(20);

    // reset clears read data; all four ports request at once
    pulse_reset();
    chk("rst2_crd", 32'(crd), 32'h0);
    mem_lat = 0;
    grants.delete();
    ra = {8'h33, 8'h22, 8'h11, 8'h00};
    rv = 4'hF;
    wait_ready(0, 1'b1, 10, n);
    chk("lat_min", 32'(n), 32'd2);
    wait_idle(60);
    chk("rr033_n", 32'(grants.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("rr033_ord", 32'(grants[i]), 32'(i));
    rv = 4'b1001;
    wait_idle(30);
    chk("rr033_wrap", 32'(grants[4]), 32'd0);

    // port 1 write alongside port 3 read
    grants.delete();
    cap_wa = '0; cap_wd = '0;
    wa[1] = 8'h20; wd[1] = 8'h33; wv[1] = 1'b1;
    ra[3] = 8'h44; rv[3] = 1'b1;
    n = 0;
    while (n < 40 && !(rv == 4'h0 && wv == 4'h0 && owner < 0)) begin
      tick();
      if (mwv) begin cap_wa = mwa; cap_wd = mwd; end
      n++;
    end
    chk("wr034_first", 32'(grants[0]), 32'd1);
    chk("wr034_second", 32'(grants[1]), 32'd3);
    chk("wr034_addr", 32'(cap_wa), 32'h20);
    chk("wr034_data", 32'(cap_wd), 32'h33);
    chk("rd034_data", 32'(crd[3]), 32'h0E);

    // spurious memory ready while idle, then held valid after ready
    spur = 1'b1;
    repeat (3) tick();
    chk("spur025", 32'(crr), 32'h0);
    grants.delete();
    hold[0] = 2;
    ra[0] = 8'h01; ra[1] = 8'h02;
    rv[0] = 1'b1; rv[1] = 1'b1;
    wait_ready(0, 1'b1, 10, n);
    hc = 1;
    while (crr[0] && hc < 20) begin
      tick();
      if (crr[0]) hc++;
    end
    chk("hold035", 32'(hc), 32'd3);
    chk("nogrant035", 32'(grants.size()), 32'd1);
    wait_idle(30);
    chk("next035", 32'(grants[1]), 32'd1);
    hold[0] = 0;
    spur = 1'b0;

    // reset in the middle of a read
    mem_lat = 5;
    ra[2] = 8'h10; rv[2] = 1'b1;
    tick();
    tick();
    chk("pre036_mrv", 32'(mrv), 32'h1);
    reset = 1'b0;
    rv = '0;
    tick();
    chk("rst036_mrv", 32'(mrv), 32'h0);
    chk("rst036_mra", 32'(mra), 32'h0);
    chk("rst036_crr", 32'(crr), 32'h0);
    reset = 1'b1;
    repeat (3) tick();
    chk("post036_crr", 32'(crr), 32'h0);
    mem_lat = 0;
    grants.delete();
    ra[0] = 8'h05; ra[3] = 8'h06;
    rv = 4'b1001;
    wait_idle(30);
    chk("rst036_grant", 32'(grants[0]), 32'd0);

`ifdef MEM_PORT_ARBITER_PERF_EN
    pulse_reset();
    mem_lat = 1;
    rv = 4'hF;
    wait_idle(80);
    rv[0] = 1'b1;
    wait_idle(30);
    chk("perf_grants", 32'(gcnt), 32'd5);
    chk("perf_stall", 32'(scnt), 32'd10);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
